// File: rtl/wishbone_register_slave_if.sv
// Wishbone classic bus bundle between a master and the register-file slave.
// Signal names keep the slave's point of view (_i driven by master, _o by slave).
interface wishbone_register_slave_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                    cyc_i;
    logic                    stb_i;
    logic                    we_i;
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic                    ack_o;
    logic                    err_o;
    logic [DATA_WIDTH-1:0]   dat_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, err_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, err_o, dat_o
    );
endinterface

// File: rtl/wishbone_register_slave.sv
// Parametrised Wishbone classic register-file slave: wait states, byte selects,
// read-only low region, error termination and cycle abort.
module wishbone_register_slave #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int DEPTH           = 1024,
    parameter int BASE_ADDRESS    = 0,
    parameter int WAIT_STATES     = 1,
    parameter int READ_ONLY_COUNT = 0,
    parameter int INIT_STEP       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    wishbone_register_slave_if.slave bus
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_WIDTH'(64'(i) * 64'(INIT_STEP));
        end
        return m;
    endfunction

    // Contents come from the configuration image, never from reset.
    mem_t mem_q = init_mem();

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   dout_q;

    logic [ADDR_WIDTH-1:0]   idx_s;
    logic                    reject_s;
    logic                    fire_s;
    logic                    wr_en_s;
    logic [DATA_WIDTH-1:0]   word_s;
    logic [DATA_WIDTH-1:0]   merged_s;

    // Decode the latched request; addresses below the base wrap high and fall out of range.
    always_comb begin
        idx_s    = adr_q - ADDR_WIDTH'(BASE_ADDRESS);
        reject_s = (64'(idx_s) >= 64'(DEPTH)) ||
                   (we_q && (64'(idx_s) < 64'(READ_ONLY_COUNT)));
        fire_s   = (state_q == ST_WAIT) && bus.cyc_i && (cnt_q == 8'd0);
        wr_en_s  = fire_s && we_q && !reject_s;
        word_s   = mem_q[idx_s[IDX_W-1:0]];
        merged_s = word_s;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel_q[k]) begin
                merged_s[8*k +: 8] = dat_q[8*k +: 8];
            end else begin
                merged_s[8*k +: 8] = word_s[8*k +: 8];
            end
        end
    end

    // Storage commit on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[idx_s[IDX_W-1:0]] <= merged_s;
        end
    end

    // Access sequencer with registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (bus.cyc_i && bus.stb_i) begin
                        adr_q   <= bus.adr_i;
                        we_q    <= bus.we_i;
                        dat_q   <= bus.dat_i;
                        sel_q   <= bus.sel_i;
                        cnt_q   <= 8'(WAIT_STATES);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= ST_RESP;
                        if (reject_s) begin
                            err_q <= 1'b1;
                        end else begin
                            ack_q  <= 1'b1;
                            dout_q <= we_q ? merged_s : word_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.dat_o = dout_q;
endmodule

// File: tb/tb_wishbone_register_slave.sv
// Randomised self-checking bench for wishbone_register_slave against an
// array-based reference of the register file and its response rules.
module tb_wishbone_register_slave;
    localparam int          DW    = 16;
    localparam int          AW    = 16;
    localparam int          DEPTH = 1024;
    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          WS    = 1;
    localparam int          ROC   = 4;
    localparam int          STEP  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wishbone_register_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wishbone_register_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDRESS(32'h100),
        .WAIT_STATES(WS), .READ_ONLY_COUNT(ROC), .INIT_STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    logic [15:0] model [DEPTH];
    logic [15:0] exp_dout;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete bus access; abort_at=n drops cyc before the n-th edge after capture.
    task automatic access(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input int abort_at, input string tag);
        logic [15:0] idx;
        logic [15:0] merged;
        logic [15:0] prev;
        logic        bad;
        logic        exp_ack;
        logic        exp_err;
        idx     = adr - BASE;
        bad     = (idx >= 16'(DEPTH)) || (we && (idx < 16'(ROC)));
        exp_ack = (abort_at == 0) && !bad;
        exp_err = (abort_at == 0) && bad;
        prev    = exp_dout;
        if (exp_ack) begin
            merged = model[idx[9:0]];
            if (we) begin
                for (int k = 0; k < 2; k++) begin
                    if (sel[k]) merged[8*k +: 8] = dat[8*k +: 8];
                end
                model[idx[9:0]] = merged;
            end
            exp_dout = merged;
        end

        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = dat;
        bus.sel_i = sel;
        @(posedge clk);
        #1;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'($urandom);
        bus.adr_i = 16'($urandom);
        bus.dat_i = 16'($urandom);
        bus.sel_i = 2'($urandom);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == abort_at || n == WS + 2) bus.cyc_i = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "/ack"}, 32'(bus.ack_o), 32'(exp_ack && (n == WS + 1)));
            check({tag, "/err"}, 32'(bus.err_o), 32'(exp_err && (n == WS + 1)));
            check({tag, "/dat"}, 32'(bus.dat_o), 32'((n > WS) ? exp_dout : prev));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 16'(i * STEP);
        exp_dout  = 16'h0000;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = 16'h0000;
        bus.dat_i = 16'h0000;
        bus.sel_i = 2'b00;
        rst_n     = 1'b0;
        #12;
        check("rst/ack", 32'(bus.ack_o), 32'h0);
        check("rst/err", 32'(bus.err_o), 32'h0);
        check("rst/dat", 32'(bus.dat_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 16'h0105, 16'h0000, 2'b00, 0, "rd105");
        check("rd105/val", 32'(bus.dat_o), 32'h000F);
        access(1'b1, 16'h0105, 16'hA533, 2'b11, 0, "wr105");
        access(1'b0, 16'h0105, 16'h0000, 2'b00, 0, "rd105b");
        check("rd105b/val", 32'(bus.dat_o), 32'hA533);
        access(1'b1, 16'h0105, 16'h00FF, 2'b01, 0, "wr105lo");
        access(1'b0, 16'h0105, 16'h0000, 2'b10, 0, "rd105c");
        check("rd105c/val", 32'(bus.dat_o), 32'hA5FF);
        access(1'b1, 16'h0105, 16'h1111, 2'b00, 0, "wr105none");
        access(1'b0, 16'h0105, 16'h0000, 2'b00, 0, "rd105d");
        access(1'b1, 16'h0101, 16'hBEEF, 2'b11, 0, "wr101ro");
        access(1'b0, 16'h0101, 16'h0000, 2'b00, 0, "rd101");
        check("rd101/val", 32'(bus.dat_o), 32'h0003);
        access(1'b0, 16'h00FF, 16'h0000, 2'b00, 0, "rd0ff");
        access(1'b0, 16'h0500, 16'h0000, 2'b00, 0, "rd500");
        access(1'b0, 16'h04FF, 16'h0000, 2'b00, 0, "rd4ff");
        check("rd4ff/val", 32'(bus.dat_o), 32'h0BFD);
        access(1'b1, 16'h0106, 16'h1234, 2'b11, 1, "wr106abort");
        access(1'b0, 16'h0106, 16'h0000, 2'b00, 0, "rd106");
        check("rd106/val", 32'(bus.dat_o), 32'h0012);
        access(1'b1, 16'h0108, 16'h5A5A, 2'b11, 2, "wr108abort0");
        access(1'b0, 16'h0108, 16'h0000, 2'b00, 0, "rd108");

        // Reset pulled during WAIT of a write: outputs clear without a clock edge.
        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = 16'h0107;
        bus.dat_i = 16'hFFFF;
        bus.sel_i = 2'b11;
        @(posedge clk);
        #1;
        bus.stb_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_dout = 16'h0000;
        check("rstmid/ack", 32'(bus.ack_o), 32'h0);
        check("rstmid/err", 32'(bus.err_o), 32'h0);
        check("rstmid/dat", 32'(bus.dat_o), 32'h0);
        @(negedge clk);
        bus.cyc_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 16'h0107, 16'h0000, 2'b00, 0, "rd107");
        check("rd107/val", 32'(bus.dat_o), 32'h0015);

        for (int t = 0; t < 250; t++) begin
            logic [15:0] a;
            int          ab;
            case ($urandom_range(0, 4))
                0:       a = 16'($urandom);
                1:       a = BASE + 16'($urandom_range(0, 7));
                2:       a = BASE + 16'($urandom_range(1016, 1023));
                3:       a = BASE + 16'($urandom_range(0, 1023));
                default: a = ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0500;
            endcase
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            access(1'($urandom), a, 16'($urandom), 2'($urandom), ab, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wishbone_register_slave.md
# wishbone_register_slave

Synthesizable, parametrised Wishbone classic single-access register-file slave; successor to the fixed 16-bit, 1024-word, one-wait-state behavioural slave used on the Modbus-to-Wishbone bus. Adds the following:
- configurable data/address width, depth and base address;
- programmable wait states;
- byte selects;
- a read-only low region;
- `err_o` for out-of-range or illegal accesses;
- cycle abort.

Sits behind the Modbus bridge as the holding/input register store.

## Interface
- `DATA_WIDTH`, 16, word width; a multiple of 8.
- `ADDR_WIDTH`, 16, `adr_i` width.
- `DEPTH`, 1024, number of words; 1..2^ADDR_WIDTH.
- `BASE_ADDRESS`, 0, address of word 0.
- `WAIT_STATES`, 1, idle cycles inserted before the response; 0..255.
- `READ_ONLY_COUNT`, 0, words at indices 0..READ_ONLY_COUNT-1 reject writes.
- `INIT_STEP`, 3, word i initialises to (i*INIT_STEP) truncated to DATA_WIDTH.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cyc_i`  in  1  bus cycle valid.
- `stb_i`  in  1  strobe.
- `we_i`  in  1  1 = write.
- `adr_i`  in  ADDR_WIDTH  word address.
- `dat_i`  in  DATA_WIDTH  write data.
- `sel_i`  in  DATA_WIDTH/8  byte enables; bit k covers dat bits [8k+7:8k].
- `ack_o`  out  1  normal termination, one-cycle pulse, registered.
- `err_o`  out  1  error termination, one-cycle pulse, registered.
- `dat_o`  out  DATA_WIDTH  read data, registered.

## Operation
- Storage array is not reset. Contents are set at configuration/initial time to i*INIT_STEP.
- Index = `adr_i` − BASE_ADDRESS, computed modulo 2^ADDR_WIDTH. Index ≥ DEPTH is out of range; this includes addresses below the base, which wrap high.
- FSM states:
  - IDLE: on `cyc_i & stb_i`, latch `adr_i`, `we_i`, `dat_i`, `sel_i`, load the wait counter with WAIT_STATES, and go to WAIT.
  - WAIT: if `cyc_i` = 0, go to IDLE with no side effects (abort). Else, if counter = 0, perform the access and go to RESP. Else decrement the counter.
  - RESP: go to IDLE unconditionally.
- Access, performed on the WAIT→RESP edge using the latched values:
  - Out of range: `err_o` <= 1; no write; `dat_o` unchanged.
  - Write to index < READ_ONLY_COUNT: `err_o` <= 1; no write; `dat_o` unchanged.
  - Write: each byte with `sel_i` set is replaced by the `dat_i` byte, the others are kept. `ack_o` <= 1. `dat_o` <= merged word. `sel_i` = 0 yields `ack_o` with no change.
  - Read: `ack_o` <= 1; `dat_o` <= stored word. `sel_i` is ignored.
- `ack_o`/`err_o` are cleared on the RESP→IDLE edge. They are never both high.
- `dat_o` holds its last value until the next successful access.
- Bus changes after the capture edge are ignored, apart from `cyc_i` abort.

## Timing
- Reset (`rst` = 0, asynchronous): `ack_o` = 0, `err_o` = 0, `dat_o` = 0, state IDLE, counter 0. The storage array is unaffected.
- Reset asserted mid-access: no write, no response. Outputs clear immediately, not at a clock edge.
- Capture edge E. `ack_o`/`err_o` rise at edge E+WAIT_STATES+1 and fall at E+WAIT_STATES+2. Example: WAIT_STATES=0 gives a response one cycle after capture.
- Back-to-back throughput: one access per WAIT_STATES+3 cycles. A strobe still high during RESP is not a new request; it is re-sampled in IDLE.
- Abort: `cyc_i` low at any WAIT edge, including the edge where counter = 0. No write, no response.
- Response occurs regardless of `stb_i` level during WAIT.

## Test plan
Configuration for all scenarios: DEPTH=1024, BASE_ADDRESS=0x100, WAIT_STATES=1, READ_ONLY_COUNT=4, INIT_STEP=3.
- Read `adr_i`=0x105, captured at edge E → `ack_o` high from E+2 to E+3 only, `dat_o`=0x000F, `err_o` stays 0.
- Write 0xA533, `sel_i`=2'b11, at 0x105; read 0x105 → 0xA533. Write 0x00FF, `sel_i`=2'b01; read → 0xA5FF. Write with `sel_i`=0 → ack, value unchanged.
- Write 0xBEEF at 0x101 (read-only) → `err_o` pulse, no `ack_o`. Read 0x101 → ack, `dat_o`=0x0003.
- Read 0x0FF and read 0x500 → `err_o` pulse each, `dat_o` keeps the previous value. Read 0x4FF → ack, `dat_o`=0x0BFD.
- Write 0x1234 at 0x106, drop `cyc_i` one cycle after capture → no ack/err. Read 0x106 → 0x0012.
- Pull `rst` low during WAIT of a write to 0x107 → outputs 0 immediately. After release, read 0x107 → 0x0015.
